// File: rtl/quad_rotary_emitter_if.sv
// Command/status bundle for the quadrature emitter.
// The master side issues step commands and an abort request.
// The slave side (the emitter) returns the quadrature pair and status.
interface quad_rotary_emitter_if #(
  parameter int CNT_W = 8
);

  // Command side
  logic             req_valid;
  logic             req_right;
  logic [CNT_W-1:0] req_count;
  logic             abort;

  // Status and waveform side
  logic             req_ready;
  logic             rot_a;
  logic             rot_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  modport master (
    output req_valid,
    output req_right,
    output req_count,
    output abort,
    input  req_ready,
    input  rot_a,
    input  rot_b,
    input  busy,
    input  done,
    input  steps_left
  );

  modport slave (
    input  req_valid,
    input  req_right,
    input  req_count,
    input  abort,
    output req_ready,
    output rot_a,
    output rot_b,
    output busy,
    output done,
    output steps_left
  );

endinterface

// File: rtl/quad_rotary_emitter.sv
// Quadrature transmitter.
// Turns (direction, detent count) commands into a legal Gray-coded A/B
// waveform that rests at 00 between detents. Each quadrature phase is held
// for PHASE_CYCLES clocks. An abort lets the detent in progress finish, so
// the outputs always return to 00 through legal single-bit steps.
module quad_rotary_emitter #(
  parameter int PHASE_CYCLES = 5000,
  parameter int CNT_W        = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,   // synchronous, active-low
  quad_rotary_emitter_if.slave    bus
);

  // Timer holds values up to PHASE_CYCLES-1; keep at least one bit.
  localparam int TMR_W = ($clog2(PHASE_CYCLES) < 1) ? 1 : $clog2(PHASE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PHASE_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_phase;
  logic             r_right;
  logic [CNT_W-1:0] r_steps;
  logic             r_abort;
  logic             r_rot_a;
  logic             r_rot_b;
  logic             r_done;

  // Next-state values
  state_t           w_state_next;
  logic [TMR_W-1:0] w_timer_next;
  logic [1:0]       w_phase_next;
  logic             w_right_next;
  logic [CNT_W-1:0] w_steps_next;
  logic             w_abort_next;
  logic             w_rot_a_next;
  logic             w_rot_b_next;
  logic             w_done_next;

  // Helpers for the transition about to happen
  logic [1:0]       w_phase_inc;
  logic             w_gray_a;
  logic             w_gray_b;
  logic             w_detent_end;
  logic             w_abort_seen;
  logic             w_last_detent;

  // Phase index after the next transition; wraps 3 -> 0 at the end of a detent.
  assign w_phase_inc  = r_phase + 2'd1;
  assign w_detent_end = (w_phase_inc == 2'd0);

  // Gray code for a given phase index. Right walks 00,10,11,01; left walks
  // the mirror sequence 00,01,11,10, so the roles of A and B simply swap.
  assign w_gray_a = r_right ? (w_phase_inc[1] ^ w_phase_inc[0]) : w_phase_inc[1];
  assign w_gray_b = r_right ? w_phase_inc[1] : (w_phase_inc[1] ^ w_phase_inc[0]);

  // An abort arriving on the very edge that closes a detent still belongs to
  // that detent, so the command ends there with a single done pulse.
  assign w_abort_seen  = r_abort | bus.abort;
  // steps_left of 1 (or 0 defensively) means this detent is the final one.
  assign w_last_detent = (r_steps <= CNT_W'(1));

  // State register: all emitter state with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_phase <= 2'd0;
      r_right <= 1'b0;
      r_steps <= '0;
      r_abort <= 1'b0;
      r_rot_a <= 1'b0;
      r_rot_b <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_phase <= w_phase_next;
      r_right <= w_right_next;
      r_steps <= w_steps_next;
      r_abort <= w_abort_next;
      r_rot_a <= w_rot_a_next;
      r_rot_b <= w_rot_b_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic: command accept, phase timing, detent counting, abort.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_phase_next = r_phase;
    w_right_next = r_right;
    w_steps_next = r_steps;
    w_abort_next = r_abort;
    w_rot_a_next = r_rot_a;
    w_rot_b_next = r_rot_b;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // abort has no meaning while idle, so the sticky flag stays clear.
        w_abort_next = 1'b0;
        if (bus.req_valid) begin
          w_right_next = bus.req_right;
          w_steps_next = bus.req_count;
          w_timer_next = TMR_RELOAD;
          w_phase_next = 2'd0;
          if (bus.req_count == '0) begin
            // Empty command: acknowledge immediately, waveform untouched.
            w_done_next = 1'b1;
          end else begin
            w_state_next = S_RUN;
          end
        end
      end

      S_RUN: begin
        w_abort_next = w_abort_seen;
        if (r_timer == '0) begin
          w_timer_next = TMR_RELOAD;
          w_phase_next = w_phase_inc;
          w_rot_a_next = w_gray_a;
          w_rot_b_next = w_gray_b;
          if (w_detent_end) begin
            if (r_steps != '0) begin
              w_steps_next = r_steps - CNT_W'(1);
            end
            if (w_last_detent || w_abort_seen) begin
              w_state_next = S_IDLE;
              w_steps_next = '0;
              w_abort_next = 1'b0;
              w_done_next  = 1'b1;
            end
          end
        end else begin
          w_timer_next = r_timer - TMR_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs come straight from registers; rot_a/rot_b are glitch-free.
  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = r_done;
  assign bus.rot_a      = r_rot_a;
  assign bus.rot_b      = r_rot_b;
  assign bus.steps_left = r_steps;

endmodule

// File: tb/tb_quad_rotary_emitter.sv
// Self-checking bench for quad_rotary_emitter (PHASE_CYCLES=4, CNT_W=8).
// Expected outputs come from closed-form rules: transition n happens at
// accept+n*P, the code is a table lookup on n mod 4, steps_left drops once
// per 4 transitions, and an abort ends the command at the next multiple of 4P.
module tb_quad_rotary_emitter;

  localparam int P     = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  quad_rotary_emitter_if #(.CNT_W(CNT_W)) bus ();

  quad_rotary_emitter #(
    .PHASE_CYCLES (P),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cmd    = 0;

  // Gray sequences indexed by (transition count mod 4).
  logic [1:0] right_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] left_seq  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  localparam logic [12:0] IDLE_PAT = {2'b00, 1'b0, 1'b0, 1'b1, 8'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [12:0] observed();
    return {bus.rot_a, bus.rot_b, bus.busy, bus.done, bus.req_ready, bus.steps_left};
  endfunction

  // Expected {A,B,busy,done,ready,steps} t clocks after the accept edge.
  function automatic logic [12:0] model(input bit right, input int cnt, input int end_t, input int t);
    int n;
    logic [1:0] ab;
    logic [7:0] st;
    n  = t / P;
    ab = right ? right_seq[n % 4] : left_seq[n % 4];
    st = (t < end_t) ? 8'(cnt - n / 4) : 8'd0;
    return {ab, 1'(t < end_t), 1'(t == end_t), 1'(t >= end_t), st};
  endfunction

  // Issue one command (entered at a negedge) and check every cycle until it ends.
  task automatic run_cmd(input bit right, input int cnt, input int abort_at,
                         input int reset_at, input int gap);
    int end_t, stop_t, ab_end;
    bit do_reset;
    logic [12:0] exp_v;

    check("ready_pre", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_right = right;
    bus.req_count = 8'(cnt);
    bus.abort     = 1'($urandom % 2);   // abort while idle must be ignored

    end_t = 4 * P * cnt;
    if (abort_at > 0) begin
      ab_end = 4 * P * ((abort_at + 4 * P - 1) / (4 * P));
      if (ab_end < end_t) end_t = ab_end;
    end
    do_reset = (reset_at > 0) && (reset_at <= end_t);
    stop_t   = do_reset ? reset_at : end_t;

    for (int t = 0; t <= stop_t; t++) begin
      if (t > 0) begin
        // req_valid junk during RUN must never be taken as a new command
        bus.req_valid = 1'($urandom % 2);
        bus.abort     = (t == abort_at);
        rst_n         = !(do_reset && t == reset_at);
      end
      @(posedge clk);
      @(negedge clk);
      if (do_reset && t >= reset_at)
        exp_v = IDLE_PAT;
      else
        exp_v = model(right, cnt, end_t, t);
      check(do_reset && t == reset_at ? "reset_mid" : "cycle", 32'(observed()), 32'(exp_v));
    end

    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;

    for (int g = 0; g < gap; g++) begin
      bus.abort = 1'($urandom % 2);
      @(posedge clk);
      @(negedge clk);
      check("idle", 32'(observed()), 32'(IDLE_PAT));
    end
    bus.abort = 1'b0;

    n_cmd++;
    $display("cmd %0d: dir=%s count=%0d abort_at=%0d reset_at=%0d end=+%0d",
             n_cmd, right ? "right" : "left", cnt, abort_at,
             do_reset ? reset_at : 0, stop_t);
  endtask

  initial begin
    int cnt, ab, rs;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_right = 1'b0;
    bus.req_count = '0;
    bus.abort     = 1'b0;

    // Reset held for two clocks
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset", 32'(observed()), 32'(IDLE_PAT));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset", 32'(observed()), 32'(IDLE_PAT));

    // Directed cases
    run_cmd(1'b1, 2, 0, 0, 1);    // right x2
    run_cmd(1'b0, 1, 0, 0, 0);    // left x1, then back-to-back
    run_cmd(1'b1, 0, 0, 0, 1);    // empty command
    run_cmd(1'b1, 3, 21, 0, 1);   // abort after 5th transition -> ends at +32
    run_cmd(1'b1, 3, 32, 0, 1);   // abort on the detent-closing edge
    run_cmd(1'b1, 3, 0, 10, 1);   // reset while A,B = 11
    run_cmd(1'b0, 5, 0, 0, 0);

    // Randomized commands
    for (int i = 0; i < 30; i++) begin
      cnt = $urandom_range(0, 4);
      ab  = 0;
      rs  = 0;
      if (cnt > 0 && ($urandom % 3) == 0) ab = $urandom_range(1, 4 * P * cnt - 1);
      if (cnt > 0 && ($urandom % 6) == 0) rs = $urandom_range(1, 4 * P * cnt - 1);
      run_cmd(1'($urandom % 2), cnt, ab, rs, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
